// File: rtl/shift_seq.sv
// shift_seq: multi-cycle SLL/SRL/SRA sequencer for the EX stage.
// Walks the power-of-two shift stages (1,2,4,8,16) one per cycle over a
// 32-bit working register. Stops after the highest set shift-amount bit and
// holds the result until the consumer accepts it.
module shift_seq (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] data_q;
  logic [4:0]  amt_q;
  logic [1:0]  op_q;
  logic [2:0]  stg_q;
  logic        live_q;
  logic [31:0] shifted;
  logic [4:0]  stage_amt;
  logic        last_stage;
  logic        accept;
  logic        unused_rs2;

  // Only the low five bits of the shift amount matter.
  assign unused_rs2 = ^i_rs2[31:5];

  // A request is taken only when the block is ready and no flush is pending.
  assign accept = i_valid && o_ready && !i_flush;

  // This stage is the last one when no higher shift-amount bits remain.
  assign last_stage = ((amt_q >> (stg_q + 3'd1)) == 5'd0);

  // Shift the working register by this stage's power-of-two width.
  always_comb begin
    stage_amt = 5'd1 << stg_q;
    case (op_q)
      2'b01:   shifted = data_q >> stage_amt;
      2'b11:   shifted = $signed(data_q) >>> stage_amt;
      default: shifted = data_q << stage_amt;
    endcase
  end

  // State register; reset forces IDLE.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Keeps o_ready low until the first edge after reset is released.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
    end
  end

  // Next-state selection; flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = (i_rs2[4:0] == 5'd0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          if (last_stage) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake and status outputs decoded from registered state only.
  always_comb begin
    o_ready  = (state_q == IDLE) && live_q;
    o_valid  = (state_q == DONE);
    o_busy   = (state_q != IDLE);
    o_result = data_q;
  end

  // Operand capture on accept and one shift stage per cycle in SHIFT.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      data_q <= 32'd0;
      amt_q  <= 5'd0;
      op_q   <= 2'd0;
      stg_q  <= 3'd0;
    end else if (!i_flush) begin
      if (state_q == IDLE && accept) begin
        data_q <= i_rs1;
        amt_q  <= i_rs2[4:0];
        op_q   <= i_op;
        stg_q  <= 3'd0;
      end else if (state_q == SHIFT) begin
        if (amt_q[stg_q]) begin
          data_q <= shifted;
        end
        stg_q <= stg_q + 3'd1;
      end
    end
  end

endmodule
